pe_mac: RTL and testbench
=========================

# pe_mac

Parametrised systolic processing element: the next generation of the 8-bit unsigned PE. It forwards both operand streams to its neighbours through one register stage and runs a 2-stage multiply-accumulate on operand pairs. It adds selectable signed/unsigned arithmetic, a saturating accumulator with a sticky overflow flag, a synchronous clear, a MAC counter, and a drain FSM that snapshots the result into a valid/ready read port. It sits in the PE array between the operand RAM feeders and the result collection logic.

## Interface
Parameters:
- DW, 8, operand width (in0/in1)
- AW, 24, accumulator/result width; AW >= 2*DW
- CW, 16, MAC counter width
- CLR_ON_DRAIN, 0, 1 = accumulator, counter and sat_flag clear in the drain capture cycle

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pe_en  in  1  enables MAC issue and load
- signed_mode  in  1  1 = two's-complement operands, accumulator and saturation; held static while pe_doing=1
- in0_vld / in0_data  in  1 / DW  row operand
- in1_vld / in1_data  in  1 / DW  column operand
- load_vld / load_data  in  1 / AW  accumulator preload
- clr  in  1  synchronous clear
- drain  in  1  snapshot request (pulse)
- out0_vld / out0_data  out  1 / DW  registered pass-through of in0
- out1_vld / out1_data  out  1 / DW  registered pass-through of in1
- rd_vld / rd_data  out  1 / AW  snapshot result
- rd_rdy  in  1  consumer accept
- pe_data  out  AW  live accumulator
- sat_flag  out  1  sticky saturation indicator
- mac_cnt  out  CW  accumulates since last clear
- pe_doing  out  1  activity indicator
- pe_busy  out  1  drain FSM not IDLE

## Operation
- Pass-through: out*_vld <= in*_vld every cycle, independent of pe_en and the FSM. out*_data loads only when in*_vld=1, else holds.
- Issue: fire = in0_vld & in1_vld & pe_en & (state==IDLE). Stage c1 registers fire and the 2*DW product. Operands are sign- or zero-extended per signed_mode.
- Accumulator update, in priority order:
  - clr: acc, sat_flag and mac_cnt go to 0; the c1 product is discarded; c1_vld is cleared.
  - load_vld & pe_en: acc <= sat(load_data + (c1_vld ? prod : 0)).
  - c1_vld: acc <= sat(acc + prod).
  - Otherwise acc holds.
- Saturation: the sum is formed at AW+1 bits.
  - Unsigned overflow clamps to 2^AW-1.
  - Signed overflow clamps to 2^(AW-1)-1 or -2^(AW-1).
  - Any clamp sets sat_flag; it stays set until clr or rst.
- mac_cnt increments on every accumulate where c1_vld=1 and clr=0, including a load+product cycle, and wraps at 2^CW.
- Drain FSM states: IDLE, FLUSH, HOLD.
  - IDLE: drain=1 moves to FLUSH; fire is blocked from the next cycle.
  - FLUSH: while c1_vld=1, stay. When c1_vld=0, rd_data <= acc, rd_vld <= 1, move to HOLD. If CLR_ON_DRAIN=1, acc, mac_cnt and sat_flag clear in the same edge.
  - HOLD: rd_vld=1 and rd_data stable. When rd_rdy=1, rd_vld <= 0 and return to IDLE.
  - drain in FLUSH/HOLD is ignored. clr in FLUSH/HOLD clears acc but does not abort the FSM; the snapshot taken is the post-clear value.
- pe_doing = fire | c1_vld | (load_vld & pe_en) | pe_busy.
- pe_data = acc.

## Timing
- Reset values: all outputs 0, state=IDLE, c1_vld=0.
- Reset mid-operation discards the in-flight product and any pending snapshot; rd_vld drops asynchronously.
- Pass-through latency: 1 cycle.
- MAC latency: operands presented in cycle t appear in pe_data at cycle t+2. Throughput is one MAC per cycle.
- Load latency: 1 cycle.
- Drain: if c1 is empty when drain is sampled, rd_vld rises 2 cycles later (one FLUSH cycle). If a product is in flight, add 1 cycle.
- rd_vld/rd_data follow valid/ready: rd_vld holds until rd_rdy, and the transfer completes on the edge where both are 1.

## Test plan
- Unsigned MAC, default params. Pairs (3,4) then (5,6) on consecutive cycles with pe_en=1 → pe_data=12, then 42; mac_cnt=2; out0_data lags in0_data by 1 cycle.
- Signed MAC, signed_mode=1. Pairs (-3 = 0xFD, 7), then (-128, -128) → pe_data=0xFFFFEB (-21), then 0x003FEB (16363).
- Saturation, unsigned: load 0xFFFF00, then 255*255 → pe_data=0xFFFFFF, sat_flag=1. Signed: load 0x800000, then -128*127 → pe_data=0x800000, sat_flag=1. clr → both reset to 0.
- Load collision: load_data=100 in the same cycle c1 holds product 20 → pe_data=120, mac_cnt+1. Repeat with pe_en=0 → load is ignored.
- Drain: accumulate to 42, pulse drain with a pair in flight, and hold rd_rdy=0 for 3 cycles.
  - Required: issue blocked; rd_vld rises 3 cycles after drain with rd_data=42 (includes the in-flight product).
  - rd_vld held until rd_rdy; pe_busy=0 the cycle after the transfer.
  - With CLR_ON_DRAIN=1: pe_data=0 at capture.
- Reset mid-drain: assert rst while in HOLD → rd_vld, pe_data and mac_cnt go to 0 immediately; FSM returns to IDLE.

Source files
------------

// File: rtl/pe_mac.sv
// Systolic PE: registered operand pass-through, 2-stage signed/unsigned MAC with a
// saturating accumulator, MAC counter and a drain FSM feeding a valid/ready snapshot port.
module pe_mac #(
   parameter int DW           = 8,
   parameter int AW           = 24,
   parameter int CW           = 16,
   parameter int CLR_ON_DRAIN = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pe_en,
   input  logic          signed_mode,
   input  logic          in0_vld,
   input  logic [DW-1:0] in0_data,
   input  logic          in1_vld,
   input  logic [DW-1:0] in1_data,
   input  logic          load_vld,
   input  logic [AW-1:0] load_data,
   input  logic          clr,
   input  logic          drain,
   output logic          out0_vld,
   output logic [DW-1:0] out0_data,
   output logic          out1_vld,
   output logic [DW-1:0] out1_data,
   output logic          rd_vld,
   output logic [AW-1:0] rd_data,
   input  logic          rd_rdy,
   output logic [AW-1:0] pe_data,
   output logic          sat_flag,
   output logic [CW-1:0] mac_cnt,
   output logic          pe_doing,
   output logic          pe_busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, HOLD = 2'd2} state_t;

   state_t            state_r, state_nxt_s;
   logic              fire_s, load_s, capture_s, release_s, cap_clr_s;
   logic              c1_vld_r;
   logic [2*DW-1:0]   c1_prod_r, prod_s, op0_s, op1_s;
   logic [AW-1:0]     acc_r, acc_nxt_s, base_s;
   logic [AW:0]       sum_s;
   logic              sat_r, sat_nxt_s;
   logic [CW-1:0]     cnt_r, cnt_nxt_s;

   // Returns {clamped, value}: a + p formed at AW+1 bits and clamped to the mode's range.
   function automatic logic [AW:0] sat_add(input logic [AW-1:0] a, input logic [2*DW-1:0] p,
                                           input logic sgn);
      logic [AW:0] a_x, p_x, sum, res;
      a_x = sgn ? {a[AW-1], a} : {1'b0, a};
      p_x = sgn ? {{(AW+1-2*DW){p[2*DW-1]}}, p} : {{(AW+1-2*DW){1'b0}}, p};
      sum = a_x + p_x;
      if (sgn) begin
         if (sum[AW] != sum[AW-1]) res = {1'b1, sum[AW], {(AW-1){~sum[AW]}}};
         else                      res = {1'b0, sum[AW-1:0]};
      end else begin
         if (sum[AW]) res = {1'b1, {AW{1'b1}}};
         else         res = {1'b0, sum[AW-1:0]};
      end
      return res;
   endfunction

   assign fire_s    = in0_vld & in1_vld & pe_en & (state_r == IDLE);
   assign load_s    = load_vld & pe_en;
   assign cap_clr_s = (CLR_ON_DRAIN != 0) && capture_s;
   assign pe_busy   = (state_r != IDLE);
   assign pe_doing  = fire_s | c1_vld_r | load_s | pe_busy;
   assign pe_data   = acc_r;
   assign sat_flag  = sat_r;
   assign mac_cnt   = cnt_r;

   // Operand extension, product and accumulator next-state with clear/load/accumulate priority.
   always_comb begin
      op0_s     = signed_mode ? {{DW{in0_data[DW-1]}}, in0_data} : {{DW{1'b0}}, in0_data};
      op1_s     = signed_mode ? {{DW{in1_data[DW-1]}}, in1_data} : {{DW{1'b0}}, in1_data};
      prod_s    = op0_s * op1_s;
      base_s    = load_s ? load_data : acc_r;
      sum_s     = sat_add(base_s, c1_vld_r ? c1_prod_r : '0, signed_mode);
      acc_nxt_s = acc_r;
      sat_nxt_s = sat_r;
      cnt_nxt_s = cnt_r;
      if (clr || cap_clr_s) begin
         acc_nxt_s = '0;
         sat_nxt_s = 1'b0;
         cnt_nxt_s = '0;
      end else if (load_s || c1_vld_r) begin
         acc_nxt_s = sum_s[AW-1:0];
         sat_nxt_s = sat_r | sum_s[AW];
         cnt_nxt_s = c1_vld_r ? cnt_r + CW'(1) : cnt_r;
      end else begin
         acc_nxt_s = acc_r;
      end
   end

   // Drain FSM next state; capture waits until the product stage is empty.
   always_comb begin
      state_nxt_s = state_r;
      capture_s   = 1'b0;
      release_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (drain) state_nxt_s = FLUSH;
            else       state_nxt_s = IDLE;
         end
         FLUSH: begin
            if (!c1_vld_r) begin
               capture_s   = 1'b1;
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = FLUSH;
            end
         end
         HOLD: begin
            if (rd_rdy) begin
               release_s   = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand pass-through to neighbouring PEs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out0_vld  <= 1'b0;
         out0_data <= '0;
         out1_vld  <= 1'b0;
         out1_data <= '0;
      end else begin
         out0_vld <= in0_vld;
         out1_vld <= in1_vld;
         if (in0_vld) out0_data <= in0_data;
         if (in1_vld) out1_data <= in1_data;
      end
   end

   // Product stage, accumulator, flag, counter and FSM state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c1_vld_r  <= 1'b0;
         c1_prod_r <= '0;
         acc_r     <= '0;
         sat_r     <= 1'b0;
         cnt_r     <= '0;
         state_r   <= IDLE;
      end else begin
         c1_vld_r <= fire_s & ~clr;
         if (fire_s) c1_prod_r <= prod_s;
         acc_r    <= acc_nxt_s;
         sat_r    <= sat_nxt_s;
         cnt_r    <= cnt_nxt_s;
         state_r  <= state_nxt_s;
      end
   end

   // Snapshot port; a clear landing on the capture edge yields the cleared value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld  <= 1'b0;
         rd_data <= '0;
      end else if (capture_s) begin
         rd_vld  <= 1'b1;
         rd_data <= clr ? '0 : acc_r;
      end else if (release_s) begin
         rd_vld  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pe_mac.sv
// Self-checking bench for pe_mac: directed vector table, drain/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_pe_mac;
   localparam int DW = 8;
   localparam int AW = 24;
   localparam int CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, pe_en, signed_mode, in0_vld, in1_vld, load_vld, clr, drain, rd_rdy;
   logic [DW-1:0] in0_data, in1_data;
   logic [AW-1:0] load_data;

   logic          out0_vld, out1_vld, rd_vld, sat_flag, pe_doing, pe_busy;
   logic [DW-1:0] out0_data, out1_data;
   logic [AW-1:0] rd_data, pe_data;
   logic [CW-1:0] mac_cnt;

   logic          b_out0_vld, b_out1_vld, b_rd_vld, b_sat_flag, b_pe_doing, b_pe_busy;
   logic [DW-1:0] b_out0_data, b_out1_data;
   logic [AW-1:0] b_rd_data, b_pe_data;
   logic [CW-1:0] b_mac_cnt;

   pe_mac #(.DW(DW), .AW(AW), .CW(CW), .CLR_ON_DRAIN(0)) dut (
      .clk(clk), .rst(rst), .pe_en(pe_en), .signed_mode(signed_mode),
      .in0_vld(in0_vld), .in0_data(in0_data), .in1_vld(in1_vld), .in1_data(in1_data),
      .load_vld(load_vld), .load_data(load_data), .clr(clr), .drain(drain),
      .out0_vld(out0_vld), .out0_data(out0_data), .out1_vld(out1_vld), .out1_data(out1_data),
      .rd_vld(rd_vld), .rd_data(rd_data), .rd_rdy(rd_rdy), .pe_data(pe_data),
      .sat_flag(sat_flag), .mac_cnt(mac_cnt), .pe_doing(pe_doing), .pe_busy(pe_busy));

   pe_mac #(.DW(DW), .AW(AW), .CW(CW), .CLR_ON_DRAIN(1)) dut_cod (
      .clk(clk), .rst(rst), .pe_en(pe_en), .signed_mode(signed_mode),
      .in0_vld(in0_vld), .in0_data(in0_data), .in1_vld(in1_vld), .in1_data(in1_data),
      .load_vld(load_vld), .load_data(load_data), .clr(clr), .drain(drain),
      .out0_vld(b_out0_vld), .out0_data(b_out0_data), .out1_vld(b_out1_vld),
      .out1_data(b_out1_data), .rd_vld(b_rd_vld), .rd_data(b_rd_data), .rd_rdy(rd_rdy),
      .pe_data(b_pe_data), .sat_flag(b_sat_flag), .mac_cnt(b_mac_cnt),
      .pe_doing(b_pe_doing), .pe_busy(b_pe_busy));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        i0v;
      logic [7:0]  i0;
      logic        i1v;
      logic [7:0]  i1;
      logic        en;
      logic        sgn;
      logic        ldv;
      logic [23:0] ld;
      logic        clr;
      logic [23:0] e_acc;
      logic        e_sat;
      logic [15:0] e_cnt;
      logic [7:0]  e_o0;
   } vec_t;

   vec_t tbl[21];

   // reference model state (mathematical values)
   longint acc_m, pv_m;
   bit     sat_m, pend_m, o0v_m, o1v_m;
   int     cnt_m;
   logic [7:0]  o0_m, o1_m;
   logic [63:0] acc_bits;

   function automatic longint ival(input logic [23:0] x, input int w, input bit sgn);
      longint v, m;
      m = longint'(1) << w;
      v = longint'({40'd0, x}) & (m - 1);
      if (sgn && v >= (m >> 1)) v = v - m;
      return v;
   endfunction

   task automatic model_step();
      longint s, hi, lo;
      bit     fire, ld;
      hi   = signed_mode ? (longint'(1) << 23) - 1 : (longint'(1) << 24) - 1;
      lo   = signed_mode ? -(longint'(1) << 23) : 0;
      fire = in0_vld && in1_vld && pe_en;
      ld   = load_vld && pe_en;
      if (clr) begin
         acc_m = 0; sat_m = 0; cnt_m = 0; pend_m = 0;
      end else begin
         if (ld || pend_m) begin
            s = ld ? ival(load_data, 24, signed_mode) : acc_m;
            if (pend_m) begin
               s = s + pv_m;
               cnt_m = (cnt_m + 1) % 65536;
            end
            if (s > hi) begin s = hi; sat_m = 1; end
            else if (s < lo) begin s = lo; sat_m = 1; end
            acc_m = s;
         end
         pend_m = fire;
         pv_m   = ival({16'd0, in0_data}, 8, signed_mode) * ival({16'd0, in1_data}, 8, signed_mode);
      end
      o0v_m = in0_vld;
      o1v_m = in1_vld;
      if (in0_vld) o0_m = in0_data;
      if (in1_vld) o1_m = in1_data;
   endtask

   task automatic idle_inputs();
      pe_en = 1'b0; signed_mode = 1'b0; in0_vld = 1'b0; in1_vld = 1'b0;
      in0_data = 8'd0; in1_data = 8'd0; load_vld = 1'b0; load_data = 24'd0;
      clr = 1'b0; drain = 1'b0; rd_rdy = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 8'h03, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 24'd0, 1'b0, 16'd0, 8'h03};
      tbl[1]  = '{1'b1, 8'h05, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 24'd12, 1'b0, 16'd1, 8'h05};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 24'd42, 1'b0, 16'd2, 8'h05};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 24'd0, 1'b1, 24'd0, 1'b0, 16'd0, 8'h05};
      tbl[4]  = '{1'b1, 8'hFD, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 24'd0, 1'b0, 16'd0, 8'hFD};
      tbl[5]  = '{1'b1, 8'h80, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 24'hFFFFEB, 1'b0, 16'd1, 8'h80};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 24'h003FEB, 1'b0, 16'd2, 8'h80};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 24'd0, 1'b1, 24'd0, 1'b0, 16'd0, 8'h80};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 24'hFFFF00, 1'b0, 24'hFFFF00, 1'b0, 16'd0, 8'h80};
      tbl[9]  = '{1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 24'hFFFF00, 1'b0, 16'd0, 8'hFF};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 24'hFFFFFF, 1'b1, 16'd1, 8'hFF};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 24'd0, 1'b1, 24'd0, 1'b0, 16'd0, 8'hFF};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h800000, 1'b0, 24'h800000, 1'b0, 16'd0, 8'hFF};
      tbl[13] = '{1'b1, 8'h80, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 24'h800000, 1'b0, 16'd0, 8'h80};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 24'h800000, 1'b1, 16'd1, 8'h80};
      tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 24'd0, 1'b1, 24'd0, 1'b0, 16'd0, 8'h80};
      tbl[16] = '{1'b1, 8'h04, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 24'd0, 1'b0, 16'd0, 8'h04};
      tbl[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 24'd100, 1'b0, 24'd120, 1'b0, 16'd1, 8'h04};
      tbl[18] = '{1'b1, 8'h04, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 24'd120, 1'b0, 16'd1, 8'h04};
      tbl[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 24'd100, 1'b0, 24'd140, 1'b0, 16'd2, 8'h04};
      tbl[20] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 24'd0, 1'b1, 24'd0, 1'b0, 16'd0, 8'h04};

      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("reset pe_data", pe_data, 24'd0);
      check("reset sat_flag", sat_flag, 1'b0);
      check("reset mac_cnt", mac_cnt, 16'd0);
      check("reset rd_vld", rd_vld, 1'b0);
      check("reset rd_data", rd_data, 24'd0);
      check("reset out_vld", {out0_vld, out1_vld}, 2'b00);
      check("reset out_data", {out0_data, out1_data}, 16'd0);
      check("reset pe_busy", pe_busy, 1'b0);
      check("reset pe_doing", pe_doing, 1'b0);

      // directed vector table
      for (int i = 0; i < 21; i++) begin
         in0_vld = tbl[i].i0v; in0_data = tbl[i].i0; in1_vld = tbl[i].i1v; in1_data = tbl[i].i1;
         pe_en = tbl[i].en; signed_mode = tbl[i].sgn; load_vld = tbl[i].ldv;
         load_data = tbl[i].ld; clr = tbl[i].clr;
         @(posedge clk); #1;
         check($sformatf("tbl%0d pe_data", i), pe_data, tbl[i].e_acc);
         check($sformatf("tbl%0d sat_flag", i), sat_flag, tbl[i].e_sat);
         check($sformatf("tbl%0d mac_cnt", i), mac_cnt, tbl[i].e_cnt);
         check($sformatf("tbl%0d out0_data", i), out0_data, tbl[i].e_o0);
      end
      idle_inputs();

      // drain with a product in flight, issue blocked, rd_rdy withheld
      pe_en = 1'b1; in0_vld = 1'b1; in1_vld = 1'b1; in0_data = 8'd3; in1_data = 8'd4;
      @(posedge clk); #1;
      in0_data = 8'd5; in1_data = 8'd6; drain = 1'b1;
      @(posedge clk); #1;
      check("drain busy", pe_busy, 1'b1);
      check("drain rd_vld early", rd_vld, 1'b0);
      drain = 1'b0; in0_data = 8'd7; in1_data = 8'd7;
      #1 check("flush pe_doing", pe_doing, 1'b1);
      @(posedge clk); #1;
      check("flush pe_data", pe_data, 24'd42);
      check("flush rd_vld", rd_vld, 1'b0);
      @(posedge clk); #1;
      check("capture rd_vld", rd_vld, 1'b1);
      check("capture rd_data", rd_data, 24'd42);
      check("blocked pe_data", pe_data, 24'd42);
      check("blocked mac_cnt", mac_cnt, 16'd2);
      check("cod rd_data", b_rd_data, 24'd42);
      check("cod pe_data", b_pe_data, 24'd0);
      check("cod mac_cnt", b_mac_cnt, 16'd0);
      in0_vld = 1'b0; in1_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d rd_vld", i), rd_vld, 1'b1);
         check($sformatf("hold%0d rd_data", i), rd_data, 24'd42);
         check($sformatf("hold%0d pe_busy", i), pe_busy, 1'b1);
      end
      rd_rdy = 1'b1;
      @(posedge clk); #1;
      rd_rdy = 1'b0;
      check("xfer rd_vld", rd_vld, 1'b0);
      check("xfer pe_busy", pe_busy, 1'b0);

      // drain with an empty product stage: two-cycle latency
      drain = 1'b1;
      @(posedge clk); #1;
      drain = 1'b0;
      check("empty drain rd_vld", rd_vld, 1'b0);
      @(posedge clk); #1;
      check("empty drain rd_vld late", rd_vld, 1'b1);
      check("empty drain rd_data", rd_data, 24'd42);
      check("empty drain cod rd_data", b_rd_data, 24'd0);

      // asynchronous reset while holding a snapshot
      #2 rst = 1'b1;
      #1;
      check("rst hold rd_vld", rd_vld, 1'b0);
      check("rst hold pe_data", pe_data, 24'd0);
      check("rst hold mac_cnt", mac_cnt, 16'd0);
      check("rst hold pe_busy", pe_busy, 1'b0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("post rst pe_busy", pe_busy, 1'b0);

      // randomized traffic against the reference model
      acc_m = 0; pv_m = 0; sat_m = 0; pend_m = 0; cnt_m = 0;
      o0_m = out0_data; o1_m = out1_data; o0v_m = 0; o1v_m = 0;
      for (int ph = 0; ph < 2; ph++) begin
         for (int c = 0; c < 300; c++) begin
            signed_mode = ph[0];
            in0_vld = ($urandom_range(0, 3) != 0); in0_data = 8'($urandom);
            in1_vld = ($urandom_range(0, 3) != 0); in1_data = 8'($urandom);
            pe_en = ($urandom_range(0, 7) != 0);
            load_vld = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
               0: load_data = 24'($urandom);
               1: load_data = 24'hFFF000 | 24'($urandom_range(0, 4095));
               default: load_data = (ph == 1) ? 24'h800000 | 24'($urandom_range(0, 4095))
                                              : 24'h7FF000 | 24'($urandom_range(0, 4095));
            endcase
            clr = (c == 0) || ($urandom_range(0, 49) == 0);
            #1 check($sformatf("rnd%0d.%0d pe_doing", ph, c), pe_doing,
                     (in0_vld & in1_vld & pe_en) | pend_m | (load_vld & pe_en));
            model_step();
            @(posedge clk); #1;
            acc_bits = acc_m;
            check($sformatf("rnd%0d.%0d pe_data", ph, c), pe_data, acc_bits[23:0]);
            check($sformatf("rnd%0d.%0d sat_flag", ph, c), sat_flag, sat_m);
            check($sformatf("rnd%0d.%0d mac_cnt", ph, c), mac_cnt, 16'(cnt_m));
            check($sformatf("rnd%0d.%0d pass", ph, c),
                  {out0_vld, out0_data, out1_vld, out1_data}, {o0v_m, o0_m, o1v_m, o1_m});
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
